rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of pending memory-write buffer entries (power of two, >=2).
REQ-002 SHALL have parameter DATA_W, default 32, register value width.
REQ-003 SHALL have the following ports:
- clk, input, 1: the single clock.
- rst, input, 1: synchronous reset, active-low; rst=0 sampled on a clk rising edge resets the block.
- wb_we, input, 1: pipeline WB stage write request; always granted, cannot be stalled.
- wb_dest, input, 4: WB destination register.
- wb_value, input, DATA_W: WB write data.
- mem_valid, input, 1: late load-return write request from the memory controller.
- mem_dest, input, 4: load destination register.
- mem_value, input, DATA_W: load data.
- mem_ready, output, 1: load write accepted this cycle (mem_valid & mem_ready = transfer).
- src1, input, 4: ID stage Rn read address.
- src2, input, 4: ID stage Rm read address.
- rf_we, output, 1: register file write enable.
- rf_dest, output, 4: register file write address.
- rf_value, output, DATA_W: register file write data.
- hazard, output, 1: ID read conflicts with a pending load write; pipeline freezes IF/ID.
- count, output, clog2(DEPTH)+1: occupied buffer entries.

Function
REQ-004 SHALL grant the register file write port by fixed priority: wb_we, then the oldest buffered entry, then an incoming load (bypass).
REQ-005 SHALL drive rf_* combinationally from the granted source; rf_we=0 when no source is active.
REQ-006 SHALL assert mem_ready = (count < DEPTH), independent of mem_valid.
REQ-007 SHALL write an accepted load straight to the register file (bypass, not buffered) when wb_we=0 and count=0.
REQ-008 SHALL otherwise push an accepted load into the buffer tail at the clk edge.
REQ-009 SHALL pop the head entry in any cycle with wb_we=0 and count>0; a pop and a push in the same cycle SHALL leave count unchanged.
REQ-010 SHALL keep the buffer FIFO-ordered with head/tail pointers wrapping modulo DEPTH.
REQ-011 SHALL invalidate, at the clk edge, every buffered entry whose dest equals wb_dest when wb_we=1, because WB is younger.
- An invalidated entry SHALL still occupy its slot and pop with rf_we=0 on its turn.
REQ-012 SHALL NOT push an accepted load coincident with wb_we=1 and mem_dest=wb_dest as a valid entry; the load is consumed and pushed invalid.
REQ-013 SHALL assert hazard combinationally when src1 or src2 matches the dest of any valid buffered entry, or of an incoming mem_valid load that is not bypassed this cycle.
REQ-014 SHALL never assert hazard for a bypassed load or a WB write; the register file provides write-before-read.
REQ-015 SHALL hold count=DEPTH with mem_ready=0 until a pop occurs; mem_valid while full SHALL be ignored.

Reset
REQ-016 SHALL, on rst=0 at a clk edge: clear pointers and all entry valid bits, set count=0, mem_ready=1, hazard=0, rf_we=0.
REQ-017 SHALL discard buffered loads on reset mid-operation without writing them to the register file.

Configuration
REQ-018 SHALL implement macro RF_WRITE_ARBITER_FORWARD_EN:
- Defined: adds outputs fwd1_valid, fwd1_value, fwd2_valid, fwd2_value. Each srcN matching a valid buffered entry SHALL forward the youngest matching entry's value with fwdN_valid=1, and hazard SHALL exclude buffered-entry matches. Incoming non-bypassed load matches SHALL still raise hazard.
- Undefined: no forwarding ports; hazard as REQ-013.

Structure
REQ-019 SHALL take REG_ADDR_W=4, DATA_W default and the rf_wr_t write-request struct (we, dest, value) from the shared package arm_pkg.
REQ-020 SHALL place buffer storage, pointers, count and invalidate-by-dest in one sub-module, rfwa_fifo; arbitration and hazard logic stay in the top.

Verification
REQ-021 Bench SHALL cover:
- Bypass: count=0, wb_we=0, mem_valid=1, mem_dest=3, mem_value=0xA5 -> same-cycle rf_we=1, rf_dest=3, rf_value=0xA5; count stays 0.
- Buffering: wb_we=1 (dest 1) for 3 cycles while loads to R4, R5, R6 arrive -> mem_ready drops after 2 accepted, count=2. When wb_we falls, R4 then R5 are written in order, then R6 is accepted.
- Invalidate: buffer holds R7=0x11; wb_we=1, wb_dest=7, wb_value=0x22 -> the R7 pop later gives rf_we=0; final R7=0x22.
- Hazard: buffer holds R2, src1=2 -> hazard=1 until the R2 pop cycle, then 0. With the macro defined: hazard=0, fwd1_valid=1, fwd1_value equals the entry value.
- Simultaneous push/pop at count=1 -> count stays 1. Pointers wrap correctly after 5 pushes with DEPTH=2.
- Reset mid-operation with count=2 -> next cycle count=0, rf_we=0, mem_ready=1, no buffered write appears.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared ARM core definitions: register address width, datapath width and the
// register-file write request carried between writeback sources and the RF.
package arm_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     value;
  } rf_wr_t;

  // True when register address a is one of the two ID-stage read addresses.
  function automatic logic addr_hit(input logic [REG_ADDR_W-1:0] a,
                                    input logic [REG_ADDR_W-1:0] b,
                                    input logic [REG_ADDR_W-1:0] c);
    return (a == b) || (a == c);
  endfunction

endpackage

// File: rtl/rfwa_fifo.sv
// Pending load-write buffer for rf_write_arbiter: a FIFO of rf_wr_t entries whose
// we bit means "still valid". RF_WRITE_ARBITER_FORWARD_EN also exports entry values.
module rfwa_fifo
  import arm_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  rf_wr_t                           push_entry,
  input  logic                             pop,
  input  logic                             inv_en,
  input  logic [REG_ADDR_W-1:0]            inv_dest,
  output rf_wr_t                           head_entry,
  output logic [$clog2(DEPTH)-1:0]         head_ptr,
  output logic [$clog2(DEPTH):0]           count,
  output logic [DEPTH-1:0]                 ent_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_dest
`ifdef RF_WRITE_ARBITER_FORWARD_EN
  ,
  output logic [DEPTH-1:0][DATA_W-1:0]     ent_value
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]                 head_q;
  logic [PTR_W-1:0]                 tail_q;
  logic [CNT_W-1:0]                 count_q;
  logic [DEPTH-1:0]                 valid_q;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] dest_q;
  logic [DEPTH-1:0][DATA_W-1:0]     value_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      // NOTE: non-blocking assignments all read pre-edge state and the last one
      // to a bit wins, so a push into a slot overrides a stale-dest invalidate.
      for (int i = 0; i < DEPTH; i++) begin
        if (inv_en && (dest_q[i] == inv_dest)) valid_q[i] <= 1'b0;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      if (push) begin
        valid_q[tail_q] <= push_entry.we;
        tail_q          <= tail_q + PTR_W'(1);
      end
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  // NOTE: payload storage is deliberately not reset; it is only ever consumed
  // through the valid bits, which are.
  always_ff @(posedge clk) begin
    if (push) begin
      dest_q[tail_q]  <= push_entry.dest;
      value_q[tail_q] <= push_entry.value;
    end
  end

  assign head_entry = '{we: valid_q[head_q], dest: dest_q[head_q], value: value_q[head_q]};
  assign head_ptr   = head_q;
  assign count      = count_q;
  assign ent_valid  = valid_q;
  assign ent_dest   = dest_q;
`ifdef RF_WRITE_ARBITER_FORWARD_EN
  assign ent_value  = value_q;
`endif

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB stage first, then buffered late loads, then a
// same-cycle load bypass; flags ID reads that collide with pending load writes.
// DATA_W must equal arm_pkg::DATA_W since entries are arm_pkg::rf_wr_t.
// Define RF_WRITE_ARBITER_FORWARD_EN to forward buffered load values to ID instead of stalling.
module rf_write_arbiter
  import arm_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = arm_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_we,
  input  logic [REG_ADDR_W-1:0]    wb_dest,
  input  logic [DATA_W-1:0]        wb_value,
  input  logic                     mem_valid,
  input  logic [REG_ADDR_W-1:0]    mem_dest,
  input  logic [DATA_W-1:0]        mem_value,
  output logic                     mem_ready,
  input  logic [REG_ADDR_W-1:0]    src1,
  input  logic [REG_ADDR_W-1:0]    src2,
  output logic                     rf_we,
  output logic [REG_ADDR_W-1:0]    rf_dest,
  output logic [DATA_W-1:0]        rf_value,
  output logic                     hazard,
  output logic [$clog2(DEPTH):0]   count
`ifdef RF_WRITE_ARBITER_FORWARD_EN
  ,
  output logic                     fwd1_valid,
  output logic [DATA_W-1:0]        fwd1_value,
  output logic                     fwd2_valid,
  output logic [DATA_W-1:0]        fwd2_value
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic                             buf_empty;
  logic                             accept;
  logic                             bypass;
  logic                             push;
  logic                             pop;
  logic                             load_hit;
  rf_wr_t                           push_entry;
  rf_wr_t                           head_entry;
  rf_wr_t                           grant;
  logic [PTR_W-1:0]                 head_ptr;
  logic [PTR_W-1:0]                 idx;
  logic [DEPTH-1:0]                 ent_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_dest;
`ifdef RF_WRITE_ARBITER_FORWARD_EN
  logic [DEPTH-1:0][DATA_W-1:0]     ent_value;
`else
  logic                             buf_hit;
`endif

  assign buf_empty = (count == '0);
  assign mem_ready = (count < CNT_W'(DEPTH));
  assign accept    = mem_valid && mem_ready;
  assign pop       = !wb_we && !buf_empty;
  assign bypass    = accept && !wb_we && buf_empty;
  assign push      = accept && !bypass;

  // A load racing a WB write to the same register is already stale: keep its slot, drop its write.
  assign push_entry = '{we: !(wb_we && (mem_dest == wb_dest)), dest: mem_dest, value: mem_value};

  rfwa_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .inv_en     (wb_we),
    .inv_dest   (wb_dest),
    .head_entry (head_entry),
    .head_ptr   (head_ptr),
    .count      (count),
    .ent_valid  (ent_valid),
    .ent_dest   (ent_dest)
`ifdef RF_WRITE_ARBITER_FORWARD_EN
    ,
    .ent_value  (ent_value)
`endif
  );

  always_comb begin
    // NOTE: the default comes first so every path assigns grant and no latch is inferred.
    grant = '0;
    if (wb_we)           grant = '{we: 1'b1, dest: wb_dest, value: wb_value};
    else if (!buf_empty) grant = head_entry;
    else if (mem_valid)  grant = '{we: 1'b1, dest: mem_dest, value: mem_value};
  end

  // Writes are held off while reset is asserted so a flushed buffer never reaches the RF.
  assign rf_we    = grant.we && rst;
  assign rf_dest  = grant.dest;
  assign rf_value = grant.value;

  assign load_hit = mem_valid && !bypass && addr_hit(mem_dest, src1, src2);

`ifdef RF_WRITE_ARBITER_FORWARD_EN
  // Walk head to tail so the youngest matching entry is the one left standing.
  always_comb begin
    idx        = head_ptr;
    fwd1_valid = 1'b0;
    fwd1_value = '0;
    fwd2_valid = 1'b0;
    fwd2_value = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_ptr + PTR_W'(k);
      if (ent_valid[idx] && (ent_dest[idx] == src1)) begin
        fwd1_valid = 1'b1;
        fwd1_value = ent_value[idx];
      end
      if (ent_valid[idx] && (ent_dest[idx] == src2)) begin
        fwd2_valid = 1'b1;
        fwd2_value = ent_value[idx];
      end
    end
  end

  assign hazard = load_hit;
`else
  // The head being popped this cycle is covered by the RF's write-before-read.
  always_comb begin
    idx     = head_ptr;
    buf_hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_ptr + PTR_W'(k);
      if (ent_valid[idx] && !(pop && (k == 0)) && addr_hit(ent_dest[idx], src1, src2))
        buf_hit = 1'b1;
    end
  end

  assign hazard = load_hit || buf_hit;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios then random traffic, every cycle
// compared with a queue model of the pending-load buffer and its priority rules.
module tb_rf_write_arbiter;
  import arm_pkg::*;

  localparam int DEPTH = 2;
  localparam int DW    = arm_pkg::DATA_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             wb_we;
  logic [3:0]       wb_dest;
  logic [DW-1:0]    wb_value;
  logic             mem_valid;
  logic [3:0]       mem_dest;
  logic [DW-1:0]    mem_value;
  logic             mem_ready;
  logic [3:0]       src1;
  logic [3:0]       src2;
  logic             rf_we;
  logic [3:0]       rf_dest;
  logic [DW-1:0]    rf_value;
  logic             hazard;
  logic [CNT_W-1:0] count;
`ifdef RF_WRITE_ARBITER_FORWARD_EN
  logic             fwd1_valid;
  logic [DW-1:0]    fwd1_value;
  logic             fwd2_valid;
  logic [DW-1:0]    fwd2_value;
`endif

  always #5 clk = ~clk;

  rf_write_arbiter #(
    .DEPTH  (DEPTH),
    .DATA_W (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_we      (wb_we),
    .wb_dest    (wb_dest),
    .wb_value   (wb_value),
    .mem_valid  (mem_valid),
    .mem_dest   (mem_dest),
    .mem_value  (mem_value),
    .mem_ready  (mem_ready),
    .src1       (src1),
    .src2       (src2),
    .rf_we      (rf_we),
    .rf_dest    (rf_dest),
    .rf_value   (rf_value),
    .hazard     (hazard),
    .count      (count)
`ifdef RF_WRITE_ARBITER_FORWARD_EN
    ,
    .fwd1_valid (fwd1_valid),
    .fwd1_value (fwd1_value),
    .fwd2_valid (fwd2_valid),
    .fwd2_value (fwd2_value)
`endif
  );

  typedef struct {
    bit          valid;
    bit [3:0]    dest;
    bit [DW-1:0] value;
  } ent_t;

  ent_t          model_q[$];
  logic [DW-1:0] rf_seen [16];
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle: compare every output against the model, record observed RF writes.
  task automatic sample();
    int          n;
    bit          byp;
    bit          e_we;
    bit [3:0]    e_dest;
    bit [DW-1:0] e_value;
    bit          e_haz;
    bit          buf_haz;
`ifdef RF_WRITE_ARBITER_FORWARD_EN
    bit          f1v, f2v;
    bit [DW-1:0] f1d, f2d;
`endif
    @(negedge clk);
    n       = model_q.size();
    byp     = mem_valid && !wb_we && (n == 0);
    e_we    = 1'b0;
    e_dest  = '0;
    e_value = '0;
    if (wb_we) begin
      e_we = 1'b1; e_dest = wb_dest; e_value = wb_value;
    end else if (n > 0) begin
      e_we = model_q[0].valid; e_dest = model_q[0].dest; e_value = model_q[0].value;
    end else if (mem_valid) begin
      e_we = 1'b1; e_dest = mem_dest; e_value = mem_value;
    end
    if (!rst) e_we = 1'b0;

    buf_haz = 1'b0;
`ifdef RF_WRITE_ARBITER_FORWARD_EN
    f1v = 1'b0; f2v = 1'b0; f1d = '0; f2d = '0;
`endif
    foreach (model_q[i]) begin
      if (model_q[i].valid) begin
        if ((i > 0 || wb_we) && (model_q[i].dest == src1 || model_q[i].dest == src2))
          buf_haz = 1'b1;
`ifdef RF_WRITE_ARBITER_FORWARD_EN
        if (model_q[i].dest == src1) begin f1v = 1'b1; f1d = model_q[i].value; end
        if (model_q[i].dest == src2) begin f2v = 1'b1; f2d = model_q[i].value; end
`endif
      end
    end
    e_haz = mem_valid && !byp && (mem_dest == src1 || mem_dest == src2);
`ifndef RF_WRITE_ARBITER_FORWARD_EN
    e_haz = e_haz || buf_haz;
`endif

    check("count", count, n);
    check("mem_ready", mem_ready, n < DEPTH);
    check("rf_we", rf_we, e_we);
    if (e_we) begin
      check("rf_dest", rf_dest, e_dest);
      check("rf_value", rf_value, e_value);
    end
    check("hazard", hazard, e_haz);
`ifdef RF_WRITE_ARBITER_FORWARD_EN
    check("fwd1_valid", fwd1_valid, f1v);
    check("fwd2_valid", fwd2_valid, f2v);
    if (f1v) check("fwd1_value", fwd1_value, f1d);
    if (f2v) check("fwd2_value", fwd2_value, f2d);
`endif
    if (rf_we === 1'b1) rf_seen[rf_dest] = rf_value;
  endtask

  // Clock edge: apply reset, pop, invalidate-by-dest and push to the model.
  task automatic advance();
    int n;
    bit acc;
    bit byp;
    @(posedge clk);
    n = model_q.size();
    if (!rst) begin
      model_q.delete();
    end else begin
      acc = mem_valid && (n < DEPTH);
      byp = acc && !wb_we && (n == 0);
      if (!wb_we && n > 0) void'(model_q.pop_front());
      if (wb_we) begin
        foreach (model_q[i]) if (model_q[i].dest == wb_dest) model_q[i].valid = 1'b0;
      end
      if (acc && !byp)
        model_q.push_back('{valid: !(wb_we && mem_dest == wb_dest), dest: mem_dest, value: mem_value});
    end
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic idle();
    wb_we = 1'b0; wb_dest = '0; wb_value = '0;
    mem_valid = 1'b0; mem_dest = '0; mem_value = '0;
    src1 = 4'hF; src2 = 4'hF;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset state
    sample();
    check("rst_count", count, 0);
    check("rst_mem_ready", mem_ready, 1);
    check("rst_hazard", hazard, 0);
    check("rst_rf_we", rf_we, 0);
    advance();

    // Bypass on an empty buffer
    mem_valid = 1'b1; mem_dest = 4'd3; mem_value = 32'hA5;
    sample();
    check("byp_we", rf_we, 1);
    check("byp_dest", rf_dest, 3);
    check("byp_value", rf_value, 32'hA5);
    advance();
    idle();
    sample();
    check("byp_count", count, 0);
    advance();

    // Buffering behind three WB cycles, then in-order drain
    wb_we = 1'b1; wb_dest = 4'd1; wb_value = 32'h100;
    mem_valid = 1'b1; mem_dest = 4'd4; mem_value = 32'h44;
    cycle();
    mem_dest = 4'd5; mem_value = 32'h55;
    cycle();
    mem_dest = 4'd6; mem_value = 32'h66;
    sample();
    check("buf_full_ready", mem_ready, 0);
    check("buf_full_count", count, 2);
    advance();
    wb_we = 1'b0;
    sample();
    check("drain_r4_dest", rf_dest, 4);
    check("drain_r4_value", rf_value, 32'h44);
    advance();
    sample();
    check("drain_r5_dest", rf_dest, 5);
    check("r6_ready", mem_ready, 1);
    advance();
    idle();
    sample();
    check("drain_r6_dest", rf_dest, 6);
    check("drain_r6_value", rf_value, 32'h66);
    advance();
    cycle();

    // Invalidate: younger WB to R7 kills the buffered R7 load
    wb_we = 1'b1; wb_dest = 4'd1; wb_value = 32'h101;
    mem_valid = 1'b1; mem_dest = 4'd7; mem_value = 32'h11;
    cycle();
    mem_valid = 1'b0; wb_dest = 4'd7; wb_value = 32'h22;
    cycle();
    idle();
    sample();
    check("inv_pop_we", rf_we, 0);
    check("inv_pop_count", count, 1);
    advance();
    sample();
    check("inv_final_r7", rf_seen[7], 32'h22);
    advance();

    // Hazard on a buffered R2 until its pop cycle
    wb_we = 1'b1; wb_dest = 4'd1; wb_value = 32'h102;
    mem_valid = 1'b1; mem_dest = 4'd2; mem_value = 32'h5C;
    cycle();
    mem_valid = 1'b0; src1 = 4'd2;
    sample();
`ifdef RF_WRITE_ARBITER_FORWARD_EN
    check("haz_fwd_hazard", hazard, 0);
    check("haz_fwd1_valid", fwd1_valid, 1);
    check("haz_fwd1_value", fwd1_value, 32'h5C);
`else
    check("haz_held", hazard, 1);
`endif
    advance();
    wb_we = 1'b0;
    sample();
    check("haz_pop_cycle", hazard, 0);
    check("haz_pop_dest", rf_dest, 2);
    advance();
    sample();
    check("haz_after", hazard, 0);
    advance();
    idle();

    // Simultaneous push/pop at count=1, wrapping the pointers several times
    wb_we = 1'b1; wb_dest = 4'd1; wb_value = 32'h103;
    mem_valid = 1'b1; mem_dest = 4'd8; mem_value = 32'h80;
    cycle();
    wb_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_dest = 4'(9 + i); mem_value = 32'h90 + i;
      sample();
      check("pp_count", count, 1);
      check("pp_dest", rf_dest, 8 + i);
      advance();
    end
    idle();
    sample();
    check("pp_last_dest", rf_dest, 13);
    check("pp_last_value", rf_value, 32'h94);
    advance();
    cycle();

    // Reset with two loads pending
    wb_we = 1'b1; wb_dest = 4'd1; wb_value = 32'h104;
    mem_valid = 1'b1; mem_dest = 4'd10; mem_value = 32'hA0;
    cycle();
    mem_dest = 4'd11; mem_value = 32'hB0;
    cycle();
    idle();
    rst = 1'b0;
    sample();
    check("rstmid_count_before", count, 2);
    check("rstmid_rf_we_in_reset", rf_we, 0);
    advance();
    rst = 1'b1;
    sample();
    check("rstmid_count", count, 0);
    check("rstmid_rf_we", rf_we, 0);
    check("rstmid_mem_ready", mem_ready, 1);
    check("rstmid_hazard", hazard, 0);
    advance();
    repeat (3) begin
      sample();
      check("rstmid_quiet", rf_we, 0);
      advance();
    end

    // Random traffic with narrow register ranges to force collisions
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 63) != 0);
      wb_we     = ($urandom_range(0, 2) == 0);
      wb_dest   = 4'($urandom_range(0, 7));
      wb_value  = $urandom;
      mem_valid = ($urandom_range(0, 1) == 1);
      mem_dest  = 4'($urandom_range(0, 7));
      mem_value = $urandom;
      src1      = 4'($urandom_range(0, 7));
      src2      = 4'($urandom_range(0, 7));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
